// File: rtl/id_ex_stage_reg.sv
// id_ex_stage_reg: ID/EX pipeline register for the 5-stage MIPS pipeline.
// Captures the ID control bundle and operand/field data, detects load-use
// and JR/JALR dependencies, stalls IF/ID and inserts bubbles into EX.
// Honours a branch flush from MEM and a global step enable from debug.
module id_ex_stage_reg #(
  parameter int          B               = 32,
  parameter int          W               = 5,
  // Reset value of bubble_count; 0 in normal use.
  parameter logic [15:0] BUBBLE_CNT_INIT = 16'h0000
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         ena,
  input  logic         flush,
  input  logic         id_valid,
  input  logic         id_wb_RegWrite,
  input  logic         id_wb_MemtoReg,
  input  logic         id_m_Jump,
  input  logic         id_m_Branch,
  input  logic         id_m_BranchNot,
  input  logic         id_m_MemRead,
  input  logic         id_m_MemWrite,
  input  logic         id_ex_RegDst,
  input  logic         id_ex_ALUSrc,
  input  logic [5:0]   id_ex_ALUOp,
  input  logic         id_jr_jalr,
  input  logic [B-1:0] id_pc_next,
  input  logic [B-1:0] id_rs_data,
  input  logic [B-1:0] id_rt_data,
  input  logic [B-1:0] id_imm,
  input  logic [W-1:0] id_rs,
  input  logic [W-1:0] id_rt,
  input  logic [W-1:0] id_rd,
  input  logic [W-1:0] id_shamt,
  output logic         ex_wb_RegWrite,
  output logic         ex_wb_MemtoReg,
  output logic         ex_m_Jump,
  output logic         ex_m_Branch,
  output logic         ex_m_BranchNot,
  output logic         ex_m_MemRead,
  output logic         ex_m_MemWrite,
  output logic         ex_ex_RegDst,
  output logic         ex_ex_ALUSrc,
  output logic [5:0]   ex_ex_ALUOp,
  output logic         ex_jr_jalr,
  output logic [B-1:0] ex_pc_next,
  output logic [B-1:0] ex_rs_data,
  output logic [B-1:0] ex_rt_data,
  output logic [B-1:0] ex_imm,
  output logic [W-1:0] ex_rs,
  output logic [W-1:0] ex_rt,
  output logic [W-1:0] ex_rd,
  output logic [W-1:0] ex_shamt,
  output logic         ex_valid,
  output logic [W-1:0] ex_dest,
  output logic         stall,
  output logic [15:0]  bubble_count
);

  // Control bundle bit positions (packed so a bubble clears it in one go).
  localparam int CW            = 16;
  localparam int C_REGWRITE    = 15;
  localparam int C_MEMTOREG    = 14;
  localparam int C_JUMP        = 13;
  localparam int C_BRANCH      = 12;
  localparam int C_BRANCHNOT   = 11;
  localparam int C_MEMREAD     = 10;
  localparam int C_MEMWRITE    = 9;
  localparam int C_REGDST      = 8;
  localparam int C_ALUSRC      = 7;
  localparam int C_ALUOP_HI    = 6;
  localparam int C_ALUOP_LO    = 1;
  localparam int C_JR          = 0;

  typedef enum logic [0:0] {
    ST_RUN     = 1'b0,
    ST_JR_WAIT = 1'b1
  } state_t;

  state_t        r_state;
  state_t        w_state_nxt;
  logic [CW-1:0] w_id_ctrl;
  logic [CW-1:0] r_ctrl;
  logic          r_valid;
  logic [B-1:0]  r_pc_next;
  logic [B-1:0]  r_rs_data;
  logic [B-1:0]  r_rt_data;
  logic [B-1:0]  r_imm;
  logic [W-1:0]  r_rs;
  logic [W-1:0]  r_rt;
  logic [W-1:0]  r_rd;
  logic [W-1:0]  r_shamt;
  logic [15:0]   r_bubble_count;
  logic [W-1:0]  w_dest;
  logic          w_gate;
  logic          w_lu;
  logic          w_jd;
  logic          w_bubble;
  logic          w_stall;

  assign w_id_ctrl = {id_wb_RegWrite, id_wb_MemtoReg, id_m_Jump, id_m_Branch,
                      id_m_BranchNot, id_m_MemRead, id_m_MemWrite, id_ex_RegDst,
                      id_ex_ALUSrc, id_ex_ALUOp, id_jr_jalr};

  // Hazard detection: load-use and JR/JALR-on-pending-write, $0 never hazards.
  always_comb begin
    w_dest = r_ctrl[C_REGDST] ? r_rd : r_rt;
    w_gate = r_valid & id_valid;
    w_lu   = 1'b0;
    w_jd   = 1'b0;
    if (w_gate) begin
      w_lu = r_ctrl[C_MEMREAD] & (r_rt != {W{1'b0}}) &
             ((r_rt == id_rs) | (r_rt == id_rt));
      w_jd = id_jr_jalr & r_ctrl[C_REGWRITE] & (w_dest != {W{1'b0}}) &
             (w_dest == id_rs);
    end else begin
      w_lu = 1'b0;
      w_jd = 1'b0;
    end
  end

  // Next-state / bubble decision; a JR behind a load needs two bubbles.
  always_comb begin
    w_state_nxt = ST_RUN;
    w_bubble    = 1'b0;
    w_stall     = 1'b0;
    case (r_state)
      ST_RUN: begin
        if (w_lu || w_jd) begin
          w_bubble = 1'b1;
          w_stall  = 1'b1;
          if (w_jd && r_ctrl[C_MEMREAD]) begin
            w_state_nxt = ST_JR_WAIT;
          end else begin
            w_state_nxt = ST_RUN;
          end
        end else begin
          w_bubble    = 1'b0;
          w_stall     = 1'b0;
          w_state_nxt = ST_RUN;
        end
      end
      ST_JR_WAIT: begin
        w_bubble    = 1'b1;
        w_stall     = 1'b1;
        w_state_nxt = ST_RUN;
      end
      default: begin
        w_bubble    = 1'b0;
        w_stall     = 1'b0;
        w_state_nxt = ST_RUN;
      end
    endcase
  end

  // A flush squashes the front end anyway, so no stall is requested then.
  assign stall = w_stall & ~flush;

  // Control bundle and valid bit: cleared on flush/bubble or invalid ID.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_ctrl  <= {CW{1'b0}};
      r_valid <= 1'b0;
    end else if (flush) begin
      r_ctrl  <= {CW{1'b0}};
      r_valid <= 1'b0;
    end else if (!ena) begin
      r_ctrl  <= r_ctrl;
      r_valid <= r_valid;
    end else if (w_bubble) begin
      r_ctrl  <= {CW{1'b0}};
      r_valid <= 1'b0;
    end else begin
      r_ctrl  <= id_valid ? w_id_ctrl : {CW{1'b0}};
      r_valid <= id_valid;
    end
  end

  // Data/field registers load whenever the stage steps (content is don't-care in a bubble).
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_pc_next <= {B{1'b0}};
      r_rs_data <= {B{1'b0}};
      r_rt_data <= {B{1'b0}};
      r_imm     <= {B{1'b0}};
      r_rs      <= {W{1'b0}};
      r_rt      <= {W{1'b0}};
      r_rd      <= {W{1'b0}};
      r_shamt   <= {W{1'b0}};
    end else if (flush || ena) begin
      r_pc_next <= id_pc_next;
      r_rs_data <= id_rs_data;
      r_rt_data <= id_rt_data;
      r_imm     <= id_imm;
      r_rs      <= id_rs;
      r_rt      <= id_rt;
      r_rd      <= id_rd;
      r_shamt   <= id_shamt;
    end else begin
      r_pc_next <= r_pc_next;
      r_rs_data <= r_rs_data;
      r_rt_data <= r_rt_data;
      r_imm     <= r_imm;
      r_rs      <= r_rs;
      r_rt      <= r_rt;
      r_rd      <= r_rd;
      r_shamt   <= r_shamt;
    end
  end

  // FSM state: flush forces RUN, disabled step holds.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ST_RUN;
    end else if (flush) begin
      r_state <= ST_RUN;
    end else if (!ena) begin
      r_state <= r_state;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Saturating bubble counter; flushes are not counted.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_bubble_count <= BUBBLE_CNT_INIT;
    end else if (flush || !ena) begin
      r_bubble_count <= r_bubble_count;
    end else if (w_bubble && (r_bubble_count != 16'hFFFF)) begin
      r_bubble_count <= r_bubble_count + 16'd1;
    end else begin
      r_bubble_count <= r_bubble_count;
    end
  end

  assign ex_wb_RegWrite = r_ctrl[C_REGWRITE];
  assign ex_wb_MemtoReg = r_ctrl[C_MEMTOREG];
  assign ex_m_Jump      = r_ctrl[C_JUMP];
  assign ex_m_Branch    = r_ctrl[C_BRANCH];
  assign ex_m_BranchNot = r_ctrl[C_BRANCHNOT];
  assign ex_m_MemRead   = r_ctrl[C_MEMREAD];
  assign ex_m_MemWrite  = r_ctrl[C_MEMWRITE];
  assign ex_ex_RegDst   = r_ctrl[C_REGDST];
  assign ex_ex_ALUSrc   = r_ctrl[C_ALUSRC];
  assign ex_ex_ALUOp    = r_ctrl[C_ALUOP_HI:C_ALUOP_LO];
  assign ex_jr_jalr     = r_ctrl[C_JR];
  assign ex_pc_next     = r_pc_next;
  assign ex_rs_data     = r_rs_data;
  assign ex_rt_data     = r_rt_data;
  assign ex_imm         = r_imm;
  assign ex_rs          = r_rs;
  assign ex_rt          = r_rt;
  assign ex_rd          = r_rd;
  assign ex_shamt       = r_shamt;
  assign ex_valid       = r_valid;
  assign ex_dest        = w_dest;
  assign bubble_count   = r_bubble_count;

endmodule
